pipeline_stall_controller: RTL and testbench

Central sequencer for the 5-stage pipeline's register enables and flushes. Combines the load-use stall request from the hazard detection unit, the branch-taken redirect, and a multi-cycle data-memory ready handshake, then drives per-stage write enables and bubble/flush controls. It sits beside the hazard detection unit and fans out to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps a saturating stall-cycle counter and a memory-wait watchdog.

---
 rtl/pipeline_stall_controller_pkg.sv | 40 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_stall_controller.sv | 111 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline control types: controller state encoding and stage-control words.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StDmemWait = 2'd1,
    StHalted   = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CtrlRun    = 7'b1101010;
  // Bubble control word: everything frozen, MEM/WB takes a bubble.
  localparam ctrl_t CtrlFreeze = 7'b0000001;
  localparam ctrl_t CtrlHalt   = 7'b0000000;

  // Branch squashes the load-use victim, so it outranks hazard_stall.
  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic hazard_stall);
    ctrl_t c;
    c = CtrlRun;
    if (branch_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (hazard_stall) begin
      c.pc_write   = 1'b0;
      c.ifid_write = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencer: merges halt, data-memory wait, branch redirect and load-use stall into
// per-stage enables/flushes, with a memory-wait watchdog and a saturating stall counter.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt,
  output logic             pc_write,
  output logic             ifId_write,
  output logic             ifId_flush,
  output logic             idEx_write,
  output logic             idEx_flush,
  output logic             exMem_write,
  output logic             memWb_bubble,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_inc;
  logic             timeout_q, timeout_d;
  logic             freeze;
  ctrl_t            ctrl, ctrl_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // In RUN halt outranks a new memory wait; an ongoing wait ignores halt until ready.
  assign freeze   = !dmem_ready &&
                    ((state_q == StDmemWait) || (state_q == StRun && !halt && dmem_req));
  assign wait_inc = (state_q == StRun) ? WaitW'(1) : wait_q + 1'b1;

  always_comb begin
    ctrl      = CtrlRun;
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StRun, StDmemWait: begin
        if (freeze) begin
          ctrl = CtrlFreeze;
          if (wait_inc >= MaxWait) begin
            timeout_d = 1'b1;
            state_d   = StHalted;
            wait_d    = '0;
          end else begin
            state_d = StDmemWait;
            wait_d  = wait_inc;
          end
        end else if (halt) begin
          ctrl    = CtrlHalt;
          state_d = StHalted;
          wait_d  = '0;
        end else begin
          ctrl    = run_ctrl(branch_taken, hazard_stall);
          state_d = StRun;
          wait_d  = '0;
        end
      end
      StHalted: begin
        ctrl = CtrlHalt;
      end
      default: begin
        ctrl    = CtrlHalt;
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  assign ctrl_out     = reset ? CtrlRun : ctrl;
  assign pc_write     = ctrl_out.pc_write;
  assign ifId_write   = ctrl_out.ifid_write;
  assign ifId_flush   = ctrl_out.ifid_flush;
  assign idEx_write   = ctrl_out.idex_write;
  assign idEx_flush   = ctrl_out.idex_flush;
  assign exMem_write  = ctrl_out.exmem_write;
  assign memWb_bubble = ctrl_out.memwb_bubble;
  assign dmem_timeout = timeout_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (!ctrl.pc_write && (state_q != StHalted)),
    .clear  (1'b0),
    .count  (stall_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed plus randomized bench for pipeline_stall_controller against a rule-level model.
module tb_pipeline_stall_controller;

  localparam int unsigned MaxWait = 4;
  localparam int unsigned CntW    = 4;
  localparam int unsigned CntMax  = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hazard_stall = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic halt = 1'b0;
  logic pc_write, ifId_write, ifId_flush, idEx_write, idEx_flush, exMem_write, memWb_bubble;
  logic dmem_timeout;
  logic [CntW-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the controller in terms of the rules: halted / waiting flags plus plain integers.
  bit m_halted, m_waiting, m_timeout;
  int m_wait, m_stall;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MAX_WAIT (MaxWait),
    .CNT_W    (CntW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt         (halt),
    .pc_write     (pc_write),
    .ifId_write   (ifId_write),
    .ifId_flush   (ifId_flush),
    .idEx_write   (idEx_write),
    .idEx_flush   (idEx_flush),
    .exMem_write  (exMem_write),
    .memWb_bubble (memWb_bubble),
    .dmem_timeout (dmem_timeout),
    .stall_count  (stall_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs_now();
    return {pc_write, ifId_write, ifId_flush, idEx_write, idEx_flush, exMem_write, memWb_bubble};
  endfunction

  // Expected {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b} from the rules.
  function automatic logic [6:0] model_outs(input bit hs, input bit br, input bit dq,
                                            input bit dr, input bit hl);
    bit mem_wait;
    if (m_halted) return 7'b0000000;
    mem_wait = m_waiting ? !dr : (dq && !dr);
    if (!m_waiting && hl) return 7'b0000000;
    if (mem_wait) return 7'b0000001;
    if (br) return 7'b1111110;
    if (hs) return 7'b0001110;
    return 7'b1101010;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_waiting = 0; m_timeout = 0; m_wait = 0; m_stall = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rst_outs"}, 16'(outs_now()), 16'h006a);
    check({tag, "_rst_cnt"}, 16'(stall_count), 16'd0);
    check({tag, "_rst_tmo"}, 16'(dmem_timeout), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  // One pipeline cycle: drive, check combinational outputs, clock, check registered state.
  task automatic cycle(input string tag, input bit hs, input bit br, input bit dq,
                       input bit dr, input bit hl);
    logic [6:0] exp;
    bit mem_wait;
    hazard_stall = hs; branch_taken = br; dmem_req = dq; dmem_ready = dr; halt = hl;
    #1;
    exp = model_outs(hs, br, dq, dr, hl);
    check({tag, "_outs"}, 16'(outs_now()), 16'(exp));
    if (!m_halted) begin
      if (!exp[6] && m_stall < int'(CntMax)) m_stall++;
      mem_wait = m_waiting ? !dr : (dq && !dr);
      if (!m_waiting && hl) begin
        m_halted = 1;
      end else if (mem_wait) begin
        m_wait = m_waiting ? m_wait + 1 : 1;
        if (m_wait >= int'(MaxWait)) begin
          m_timeout = 1; m_halted = 1; m_waiting = 0;
        end else begin
          m_waiting = 1;
        end
      end else begin
        m_waiting = 0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_cnt"}, 16'(stall_count), 16'(m_stall));
    check({tag, "_tmo"}, 16'(dmem_timeout), 16'(m_timeout));
  endtask

  initial begin
    bit hs, br, dq, dr, hl;
    model_reset();
    #2;
    do_reset("init");

    // Load-use stall for one cycle.
    cycle("hz1", 1, 0, 0, 0, 0);
    check("hz1_count_one", 16'(stall_count), 16'd1);
    cycle("idle", 0, 0, 0, 0, 0);

    // Three wait cycles, then ready; branch held through the freeze.
    cycle("dm_w1", 0, 1, 1, 0, 0);
    cycle("dm_w2", 1, 1, 1, 0, 0);
    cycle("dm_w3", 0, 1, 1, 0, 0);
    cycle("dm_rdy", 0, 1, 1, 1, 0);
    check("dm_count", 16'(stall_count), 16'd4);

    // Branch and hazard together: branch wins, no stall cycle.
    cycle("br_hz", 1, 1, 0, 0, 0);
    check("br_hz_count", 16'(stall_count), 16'd4);

    // Watchdog: ready held low for MaxWait cycles.
    for (int i = 0; i < 4; i++) cycle("tmo_w", 0, 0, 1, 0, 0);
    check("tmo_flag", 16'(dmem_timeout), 16'd1);
    cycle("tmo_halted", 1, 1, 1, 1, 0);
    do_reset("after_tmo");

    // Halt, then later inputs ignored.
    cycle("halt", 0, 0, 0, 0, 1);
    cycle("halt_br", 0, 1, 0, 0, 0);
    cycle("halt_hz", 1, 0, 1, 0, 1);
    do_reset("after_halt");

    // Saturation of the stall counter.
    for (int i = 0; i < 20; i++) cycle("sat", 1, 0, 0, 0, 0);
    check("sat_value", 16'(stall_count), 16'(CntMax));

    // Asynchronous reset in the middle of a memory wait.
    do_reset("pre_mid");
    cycle("mid_w1", 0, 0, 1, 0, 0);
    cycle("mid_w2", 0, 0, 1, 0, 0);
    do_reset("mid_wait");
    cycle("mid_after", 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset("rnd");
      hs = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      dq = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 1) == 0);
      hl = ($urandom_range(0, 59) == 0);
      if (m_waiting && dr) hl = 0;
      cycle("rnd", hs, br, dq, dr, hl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
